// File: rtl/nios_core_pio_bidir.sv
// Avalon-MM bidirectional GPIO for the Nios core: per-bit direction, optional open-drain, edge capture with irq mask.
// Single-cycle writes, 1-cycle registered reads, input visible in sync2 two edges after a pin change; no backpressure.
module nios_core_pio_bidir #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter int              OPEN_DRAIN  = 0,
    parameter int              EDGE_TYPE   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [WIDTH-1:0]  out_port,
    output logic [WIDTH-1:0]  oe,
    output logic              irq
);

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_dir;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_sync3;
    logic [1:0]       r_supp_cnt;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic [WIDTH-1:0] w_edge_raw;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_rd_val;
    logic             w_unused;

    assign w_wr     = chipselect && !write_n;
    assign w_wd     = writedata[WIDTH-1:0];
    assign w_unused = ^writedata;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge_raw = r_sync2 & ~r_sync3;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge_raw = ~r_sync2 & r_sync3;
        end else begin : g_any
            assign w_edge_raw = r_sync2 ^ r_sync3;
        end
    endgenerate

    // Sync flops come out of reset at 0, so the first pin samples would look like edges
    assign w_edge = (r_supp_cnt == 2'd3) ? w_edge_raw : '0;
    assign w_clr  = (w_wr && address == 3'd3) ? w_wd : '0;

    always_comb begin
        w_rd_val = '0;
        case (address)
            3'd0:    w_rd_val[WIDTH-1:0] = r_sync2;
            3'd1:    w_rd_val[WIDTH-1:0] = r_dir;
            3'd2:    w_rd_val[WIDTH-1:0] = r_irqmask;
            3'd3:    w_rd_val[WIDTH-1:0] = r_edgecap;
            default: w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= DIR_RESET;
            r_irqmask  <= '0;
            r_edgecap  <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_sync3    <= '0;
            r_supp_cnt <= 2'd0;
            r_readdata <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (r_supp_cnt != 2'd3) begin
                r_supp_cnt <= r_supp_cnt + 2'd1;
            end
            if (w_wr) begin
                case (address)
                    3'd0:    r_data_out <= w_wd;
                    3'd1:    r_dir      <= w_wd;
                    3'd2:    r_irqmask  <= w_wd;
                    3'd4:    r_data_out <= r_data_out | w_wd;
                    3'd5:    r_data_out <= r_data_out & ~w_wd;
                    default: ;
                endcase
            end
            // A fresh edge beats a simultaneous write-1-to-clear
            r_edgecap  <= (r_edgecap & ~w_clr) | w_edge;
            r_readdata <= w_rd_val;
        end
    end

    generate
        if (OPEN_DRAIN != 0) begin : g_od
            assign out_port = '0;
            assign oe       = r_dir & ~r_data_out;
        end else begin : g_pp
            assign out_port = r_data_out;
            assign oe       = r_dir;
        end
    endgenerate

    assign readdata = r_readdata;
    assign irq      = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_nios_core_pio_bidir.sv
// Bench for nios_core_pio_bidir: push-pull rising-edge instance plus an open-drain any-edge instance on a shared bus.
module tb_nios_core_pio_bidir;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic [7:0]  oe;
    logic        irq;

    logic [31:0] od_readdata;
    logic [7:0]  od_out;
    logic [7:0]  od_oe;
    logic        od_irq;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    nios_core_pio_bidir #(
        .WIDTH(8), .RESET_VALUE(8'h00), .DIR_RESET(8'h00), .OPEN_DRAIN(0), .EDGE_TYPE(0)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    nios_core_pio_bidir #(
        .WIDTH(8), .RESET_VALUE(8'h03), .DIR_RESET(8'h0F), .OPEN_DRAIN(1), .EDGE_TYPE(2)
    ) u_od (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(od_readdata),
        .in_port(in_port), .out_port(od_out), .oe(od_oe), .irq(od_irq)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back(exp);
        tick();
        chipselect = 1'b0;
        chk(tag, readdata, exp_q.pop_front());
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_port    = 8'h00;
        repeat (3) tick();

        chk("rst_out", 32'(out_port), 32'h0);
        chk("rst_oe", 32'(oe), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", readdata, 32'h0);
        chk("rst_od_oe", 32'(od_oe), 32'h0C);
        chk("rst_od_out", 32'(od_out), 32'h0);
        chk("rst_od_rdata", od_readdata, 32'h0);

        reset_n = 1'b1;
        repeat (4) tick();

        // Basic drive and loopback read
        wr(3'd0, 32'h0000_00A5);
        wr(3'd1, 32'h0000_00FF);
        chk("t1_out", 32'(out_port), 32'hA5);
        chk("t1_oe", 32'(oe), 32'hFF);
        chk("t1_od_oe", 32'(od_oe), 32'h5A);
        chk("t1_od_out", 32'(od_out), 32'h0);
        in_port = 8'hA5;
        tick();
        tick();
        rd("t1_rd_data", 3'd0, 32'h0000_00A5);
        rd("t1_rd_edgecap", 3'd3, 32'h0000_00A5);
        chk("t1_irq_masked", 32'(irq), 32'h0);
        wr(3'd3, 32'h0000_00FF);
        rd("t1_edgecap_clr", 3'd3, 32'h0);

        // Atomic set/clear and unused upper write bits
        wr(3'd0, 32'h0000_00F0);
        chk("t2_out_f0", 32'(out_port), 32'hF0);
        wr(3'd4, 32'h0000_0003);
        chk("t2_outset", 32'(out_port), 32'hF3);
        wr(3'd5, 32'h0000_0030);
        chk("t2_outclr", 32'(out_port), 32'hC3);
        rd("t2_rd_outset", 3'd4, 32'h0);
        rd("t2_rd_outclr", 3'd5, 32'h0);
        rd("t2_rd_addr7", 3'd7, 32'h0);
        wr(3'd0, 32'hFFFF_FF12);
        chk("t2_upper_ignored", 32'(out_port), 32'h12);
        rd("t2_rd_dir", 3'd1, 32'h0000_00FF);
        wr(3'd2, 32'hFFFF_FF04);
        rd("t2_rd_mask", 3'd2, 32'h0000_0004);

        // Open-drain drive
        wr(3'd1, 32'h0000_0001);
        wr(3'd0, 32'h0000_0000);
        chk("t3_od_oe_low", 32'(od_oe), 32'h01);
        chk("t3_od_out", 32'(od_out), 32'h0);
        chk("t3_pp_oe", 32'(oe), 32'h01);
        wr(3'd0, 32'h0000_0001);
        chk("t3_od_release", 32'(od_oe), 32'h0);
        chk("t3_pp_out", 32'(out_port), 32'h01);

        // Edge capture timing, clear, and set-beats-clear
        in_port = 8'h00;
        repeat (3) tick();
        wr(3'd3, 32'h0000_00FF);
        chk("t4_irq_idle", 32'(irq), 32'h0);
        chk("t4_od_irq_idle", 32'(od_irq), 32'h0);
        in_port = 8'h04;
        tick();
        chk("t4_irq_k", 32'(irq), 32'h0);
        tick();
        chk("t4_irq_k1", 32'(irq), 32'h0);
        tick();
        chk("t4_irq_k2", 32'(irq), 32'h1);
        chk("t4_od_irq_k2", 32'(od_irq), 32'h1);
        rd("t4_rd_edgecap", 3'd3, 32'h0000_0004);
        wr(3'd3, 32'h0000_0004);
        chk("t4_irq_cleared", 32'(irq), 32'h0);
        chk("t4_od_irq_cleared", 32'(od_irq), 32'h0);
        in_port = 8'h00;
        repeat (3) tick();
        chk("t4_fall_ignored", 32'(irq), 32'h0);
        chk("t4_od_fall_any", 32'(od_irq), 32'h1);
        wr(3'd3, 32'h0000_0004);
        in_port = 8'h04;
        tick();
        tick();
        wr(3'd3, 32'h0000_0004);
        chk("t4_set_wins", 32'(irq), 32'h1);
        rd("t4_rd_set_wins", 3'd3, 32'h0000_0004);
        wr(3'd3, 32'h0000_0004);
        chk("t4_irq_cleared2", 32'(irq), 32'h0);

        // Reset overrides a simultaneous write while irq is pending
        in_port = 8'h00;
        repeat (3) tick();
        in_port = 8'h04;
        repeat (3) tick();
        chk("t6_irq_pending", 32'(irq), 32'h1);
        reset_n    = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0000_0055;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #2;
        chk("t6_no_edge_out", 32'(out_port), 32'h01);
        chk("t6_no_edge_irq", 32'(irq), 32'h1);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk("t6_out", 32'(out_port), 32'h0);
        chk("t6_oe", 32'(oe), 32'h0);
        chk("t6_irq", 32'(irq), 32'h0);
        chk("t6_rdata", readdata, 32'h0);
        chk("t6_od_oe", 32'(od_oe), 32'h0C);

        // Pins high through reset release must not register edges
        in_port = 8'hFF;
        tick();
        tick();
        reset_n = 1'b1;
        wr(3'd2, 32'h0000_00FF);
        for (int i = 0; i < 8; i++) begin
            chk("t5_irq", 32'(irq), 32'h0);
            chk("t5_od_irq", 32'(od_irq), 32'h0);
            tick();
        end
        rd("t5_rd_edgecap", 3'd3, 32'h0);
        rd("t5_rd_data", 3'd0, 32'h0000_00FF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
